// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Producer side of the decode pipeline register. Owns the fetch PC, issues
// instruction reads on an SRAM-like bus (request / address-accepted /
// data-valid), and hands {instr, pc, pcplus4} to decode through a one-entry
// output buffer with a valid/ready handshake. Redirects from later stages
// reload the PC and squash the response of any fetch already in flight.
//
// At most one bus request is ever outstanding. A request only issues while
// the output buffer is empty or draining, so a response always finds room.
//
// Ports
//   clk             clock, all state changes on the rising edge
//   reset           asynchronous active-low reset (0 = in reset)
//   inst_req        fetch request to the instruction bus
//   inst_addr       fetch byte address (the current pc)
//   inst_addr_ok    bus accepted the request this cycle
//   inst_data_ok    read data valid this cycle
//   inst_rdata      read data
//   redirect_valid  load redirect_pc this cycle (highest priority)
//   redirect_pc     redirect target
//   d_valid         output entry valid
//   d_ready         decode accepts the entry
//   d_instr         instruction word
//   d_pc            address of d_instr
//   d_pcplus4       d_pc + 4
//   d_adel          address-error flag (only with FETCH_ADEL_EN)
//   pc              current fetch PC, for debug
//
// Build option
//   FETCH_ADEL_EN   when defined, a misaligned pc is not fetched; instead an
//                   entry flagged d_adel is delivered and fetch halts until
//                   the next redirect. When undefined, a misaligned pc is
//                   driven unmodified on inst_addr.
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic [31:0] d_pcplus4,
`ifdef FETCH_ADEL_EN
  output logic        d_adel,
`endif
  output logic [31:0] pc
);

  // REQ: nothing outstanding. WAIT: one request outstanding.
  // HALT: parked after an address error, waiting for a redirect.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1
`ifdef FETCH_ADEL_EN
    ,
    S_HALT = 2'd2
`endif
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] req_pc;     // address of the outstanding request
  logic        discard;    // outstanding response belongs to a squashed path

  logic        space;      // buffer empty or being drained this cycle
  logic        accept;     // bus takes our request this cycle
  logic        resp;       // response for the outstanding request
  logic        resp_keep;  // response is current-path and gets buffered
  logic        misaligned;
  logic        adel_fill;  // deliver an address-error entry instead of fetching

  assign space = ~d_valid | d_ready;

`ifdef FETCH_ADEL_EN
  assign misaligned = |pc[1:0];
  assign adel_fill  = (state == S_REQ) & space & misaligned & ~redirect_valid;
`else
  assign misaligned = 1'b0;
  assign adel_fill  = 1'b0;
`endif

  // Gated by reset so the bus sees no request while the block is held.
  assign inst_req  = reset & (state == S_REQ) & space & ~redirect_valid & ~misaligned;
  assign inst_addr = pc;
  assign accept    = inst_req & inst_addr_ok;

  // data_ok outside WAIT is a bus protocol violation and is ignored.
  assign resp      = (state == S_WAIT) & inst_data_ok;
  // A response landing in a redirect cycle is stale even with discard clear.
  assign resp_keep = resp & ~discard & ~redirect_valid;

  // ---------------------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of its inputs regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_REQ;
    else        state <= state_nx;
  end

  // NOTE: state_nx gets its default before the case so every path assigns
  // it; a missing assignment in combinational logic would infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      S_REQ: begin
        if (accept)         state_nx = S_WAIT;
`ifdef FETCH_ADEL_EN
        else if (adel_fill) state_nx = S_HALT;
`endif
      end
      S_WAIT: begin
        // A redirect without data_ok keeps us waiting for the stale reply.
        if (inst_data_ok) state_nx = S_REQ;
      end
`ifdef FETCH_ADEL_EN
      S_HALT: begin
        if (redirect_valid) state_nx = S_REQ;
      end
`endif
      default: state_nx = S_REQ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // PC, outstanding-request tracking and squash flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= RESET_PC;
      req_pc  <= 32'd0;
      discard <= 1'b0;
    end else begin
      if (redirect_valid) pc <= redirect_pc;
      else if (accept)    pc <= pc + PC_INC;

      if (accept) req_pc <= pc;

      // The single outstanding reply clears the flag whichever path it is on;
      // back-to-back redirects simply leave it set.
      if (resp)                                      discard <= 1'b0;
      else if (redirect_valid && (state == S_WAIT))  discard <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // One-entry output buffer
  // ---------------------------------------------------------------------------
  // Priority: redirect flush, fill from bus, fill with address error, drain.
  // A fill in the same cycle as a transfer replaces the departing entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_valid   <= 1'b0;
      d_instr   <= 32'd0;
      d_pc      <= 32'd0;
      d_pcplus4 <= 32'd0;
`ifdef FETCH_ADEL_EN
      d_adel    <= 1'b0;
`endif
    end else if (redirect_valid) begin
      d_valid <= 1'b0;
    end else if (resp_keep) begin
      d_valid   <= 1'b1;
      d_instr   <= inst_rdata;
      d_pc      <= req_pc;
      d_pcplus4 <= req_pc + 32'd4;
`ifdef FETCH_ADEL_EN
      d_adel    <= 1'b0;
`endif
    end else if (adel_fill) begin
      d_valid   <= 1'b1;
      d_instr   <= 32'd0;
      d_pc      <= pc;
      d_pcplus4 <= pc + 32'd4;
`ifdef FETCH_ADEL_EN
      d_adel    <= 1'b1;
`endif
    end else if (d_ready) begin
      d_valid <= 1'b0;
    end
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Producer side of the decode pipeline register: owns the PC and issues instruction fetches on an SRAM-like instruction bus.
- Delivers {instr, pc, pcplus4} to decode through a one-entry output buffer with a valid/ready handshake.
- Takes redirect requests (branch, jump, exception) from later stages and drops any stale in-flight responses.
- Sits between the instruction cache/bus bridge and the decode register.

Parameters:
- RESET_PC, 32'hBFC0_0000, PC value loaded on reset.
- PC_INC, 4, byte increment between sequential fetches.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- inst_req  out  1  fetch request to instruction bus
- inst_addr  out  32  fetch byte address
- inst_addr_ok  in  1  bus accepted request this cycle
- inst_data_ok  in  1  read data valid this cycle
- inst_rdata  in  32  read data
- redirect_valid  in  1  load new PC this cycle
- redirect_pc  in  32  redirect target
- d_valid  out  1  output entry valid
- d_ready  in  1  decode accepts entry (not stalled)
- d_instr  out  32  instruction word
- d_pc  out  32  address of d_instr
- d_pcplus4  out  32  d_pc + 4
- pc  out  32  current architectural fetch PC, for debug

Behaviour:
- Reset (asynchronous, while reset=0):
  - pc = RESET_PC; state = REQ; discard = 0.
  - d_valid = 0; d_instr, d_pc, d_pcplus4 = 0; inst_req = 0.
- State machine, two states:
  - REQ: no request outstanding.
  - WAIT: one request outstanding. At most one request is ever outstanding.
- space = ~d_valid | d_ready.
- inst_req = (state==REQ) & space & ~redirect_valid. inst_addr = pc (combinational).
- REQ transition: on inst_req & inst_addr_ok, latch req_pc <= pc, pc <= pc + PC_INC (32-bit wrap, no carry out), state <= WAIT. While addr_ok is low, req stays asserted and inst_addr stays stable, unless a redirect arrives or space drops.
- WAIT transition: on inst_data_ok, state <= REQ.
  - If discard = 0: buffer <= {inst_rdata, req_pc, req_pc+4}, d_valid <= 1.
  - If discard = 1: the data is dropped and discard <= 0.
- Buffer has room on every response: a request issues only when space = 1, so the buffer is empty or draining when the response returns.
- Handshake:
  - An entry transfers on d_valid & d_ready; d_valid <= 0 unless refilled in the same cycle.
  - Outputs hold stable while d_valid & ~d_ready.
- Redirect (highest priority):
  - pc <= redirect_pc and d_valid <= 0.
  - If state==WAIT and no data_ok this cycle: discard <= 1.
  - If data_ok arrives in the redirect cycle, the data is dropped and discard stays 0.
  - No request issues in the redirect cycle.
  - Back-to-back redirects: the last one wins; discard stays set until the single outstanding response returns.
- Latency:
  - Redirect at cycle t: the new PC is on inst_addr at t+1.
  - Zero-wait bus (addr_ok in the issue cycle, data_ok one cycle later): d_valid rises the cycle after data_ok; sustained throughput is one instruction per 2 cycles.
- inst_data_ok while in REQ is a bus protocol violation; it is ignored.

Optional Feature:
- Macro FETCH_ADEL_EN, compiled in: adds output port d_adel (1).
  - In REQ with space and pc[1:0] != 0: no bus request issues.
  - The buffer is filled with {d_instr=0, d_pc=pc, d_pcplus4=pc+4, d_adel=1}, state <= HALT.
  - HALT issues nothing until redirect_valid, which returns to REQ.
  - d_adel = 0 on every normal entry and on reset.
- Compiled out: no d_adel port and no HALT state; a misaligned pc is driven unmodified on inst_addr.

Test Plan:
- Reset release, zero-wait bus, d_ready=1 → inst_addr sequence BFC00000, BFC00004, BFC00008; d_pc matches each, d_pcplus4 = d_pc+4, d_instr equals the returned rdata.
- d_ready held 0 for 5 cycles after the first entry → d_valid=1 with outputs stable; inst_req=0 throughout; no second response captured; fetch resumes the cycle d_ready rises.
- addr_ok delayed 3 cycles → inst_req and inst_addr=BFC00004 held stable over 3 cycles; pc advances only on the accept.
- Redirect to 80001000 while in WAIT, data_ok 2 cycles later with rdata DEADBEEF → DEADBEEF never appears on d_instr; next d_pc = 80001000.
- redirect_valid in the same cycle as data_ok → data dropped, discard stays 0; next response to 80001000 is delivered.
- FETCH_ADEL_EN defined, redirect to 80001002 → no inst_req; d_valid=1, d_adel=1, d_pc=80001002; stays idle until redirect to 80001004, then a normal fetch with d_adel=0.
